hd44780_msg_sequencer: RTL and testbench
========================================

# hd44780_msg_sequencer

Button-driven message sequencer that sits between board-level glue and `hd44780_controller`. It debounces a raw push-button and walks a parametrised table of RAM start addresses. For each message it issues a one-cycle controller strobe, then supervises the controller's busy/error handshake with a timeout. Status goes out on active-low LEDs and a logic-analyser trigger. It replaces the fixed single-message "hello" state machine with N messages, selectable run modes and fault detection.

## Interface
Parameters:
- `ADDR_BITS`, 8, width of one controller start address
- `NUM_MSGS`, 4, number of message slots (≥1)
- `IDX_BITS`, 2, width of message index (≥ clog2(NUM_MSGS), ≥1)
- `DEBOUNCE_BITS`, 16, debounce window is 2^DEBOUNCE_BITS cycles
- `TIMEOUT_BITS`, 24, handshake timeout is 2^TIMEOUT_BITS−1 cycles
- `HEART_BITS`, 23, heartbeat LED toggles every 2^(HEART_BITS−1) cycles
- `AUTO_RUN`, 0: 1 = one press plays all messages back-to-back; 0 = one message per press
- `WRAP`, 1: 1 = after last message return to index 0 and IDLE; 0 = stop in DONE

Ports:
- `CLK_I`  in  1  system clock
- `RST_I`  in  1  reset, asynchronous, active-low
- `i_button`  in  1  raw button, active-high, asynchronous to CLK_I
- `i_start_addrs`  in  NUM_MSGS*ADDR_BITS  slot k at bits [k*ADDR_BITS +: ADDR_BITS], quasi-static
- `i_cont_busy`  in  1  controller busy
- `i_cont_error`  in  1  controller error, valid when busy falls
- `o_cont_stb`  out  1  one-cycle start strobe to controller
- `o_start_addr`  out  ADDR_BITS  registered address of current slot
- `o_msg_index`  out  IDX_BITS  current slot index
- `o_done`  out  1  high in DONE
- `o_fault`  out  1  high in FAULT
- `o_logan_strobe`  out  1  sticky; rises on first accepted press
- `o_led`  out  4  active-low: [0] running, [1] done, [2] fault, [3] heartbeat

## Operation
- Button path: 2-flop synchroniser, then debouncer. A counter counts consecutive cycles with sync ≠ debounced level and clears otherwise. After 2^DEBOUNCE_BITS such cycles the debounced level flips and the counter clears. A press is the debounced rising edge, a one-cycle pulse.
- FSM states: IDLE, STROBE, ARM, WAIT, NEXT, DONE, FAULT.
- IDLE: on press → STROBE; set `o_logan_strobe`.
- STROBE: `o_cont_stb`=1 for exactly this cycle. `o_start_addr` is loaded from slot[`o_msg_index`] on entry. Timeout counter is cleared. → ARM.
- ARM: wait for busy=1 → WAIT. Counter reaches 2^TIMEOUT_BITS−1 → FAULT.
- WAIT: busy=0 → if `i_cont_error`=1 then FAULT, else NEXT. Timeout counter restarts on entry. Timeout → FAULT.
- NEXT, index < NUM_MSGS−1: index+1. If AUTO_RUN go to STROBE, else IDLE.
- NEXT, last index: if WRAP, index←0 → IDLE; else → DONE.
- DONE and FAULT: absorbing. Only reset leaves them. Presses are ignored.
- Presses arriving outside IDLE are dropped, not queued.
- LEDs (active-low):
  - [0]=0 in STROBE/ARM/WAIT/NEXT
  - [1]=0 in DONE
  - [2]=0 in FAULT
  - [3] = heartbeat counter MSB, free-running in every state
- Index arithmetic is modulo NUM_MSGS. The index never exceeds NUM_MSGS−1 even when 2^IDX_BITS > NUM_MSGS.

## Timing
- Reset (RST_I=0, async) holds the following; all counters and synchronisers also clear:
  - state=IDLE, index=0
  - `o_cont_stb`=0, `o_start_addr`=0, `o_done`=0, `o_fault`=0, `o_logan_strobe`=0
  - `o_led`=4'b1111, heartbeat counter=0
- Press latency: `i_button` is first sampled high at edge k and held. Debounced level rises at edge k+1+2^DEBOUNCE_BITS. `o_cont_stb` is high for the cycle after edge k+2+2^DEBOUNCE_BITS.
- Strobe to controller: single cycle. `o_start_addr` is valid on the same cycle and held until the next STROBE.
- Busy asserted the same cycle as the strobe is not seen. ARM samples from the cycle after STROBE.
- Busy already high on entry to ARM → WAIT on the next edge.
- Busy falling with error=1 → FAULT even on the last slot. Error is ignored while busy=1.
- AUTO_RUN back-to-back: busy=0 seen in WAIT → NEXT → next strobe is 2 cycles after the busy-low sample.
- Reset mid-handshake: outputs return to reset values immediately. No strobe is reissued until a new press.

## Test plan
Bench settings: DEBOUNCE_BITS=2, TIMEOUT_BITS=4, NUM_MSGS=3, IDX_BITS=2, slots = {0x00, 0x20, 0x40}. The controller model asserts busy 1 cycle after the strobe and holds it for 5 cycles.

- Clean press, AUTO_RUN=0, WRAP=1: button high from edge 0 → `o_cont_stb` pulse in the cycle after edge 6, `o_start_addr`=0x00, `o_led[0]`=0 while busy. After completion, index=1, IDLE, `o_logan_strobe`=1.
- Bounce: button toggles every cycle for 10 cycles, then stays low → no strobe, `o_logan_strobe`=0.
- AUTO_RUN=1, WRAP=0: one press → three strobes with addresses 0x00, 0x20, 0x40, each 2 cycles after busy falls. Then `o_done`=1, `o_led`=4'b?101 (bit 3 heartbeat). Further presses cause no strobe.
- WRAP=1, AUTO_RUN=0: four presses → addresses 0x00, 0x20, 0x40, 0x00; index is 1 at the end.
- Controller never asserts busy → FAULT 15 cycles after STROBE, `o_fault`=1, `o_led[2]`=0. Busy falls with error=1 → FAULT.
- RST_I pulled low in WAIT → all outputs at reset values asynchronously. After release, a new press strobes 0x00.

Source files
------------

// File: rtl/hd44780_msg_sequencer.sv
// Button-driven sequencer that walks a table of controller start addresses,
// strobing the HD44780 controller once per message and supervising its busy/error handshake.
module hd44780_msg_sequencer #(
    parameter int ADDR_BITS     = 8,
    parameter int NUM_MSGS      = 4,
    parameter int IDX_BITS      = 2,
    parameter int DEBOUNCE_BITS = 16,
    parameter int TIMEOUT_BITS  = 24,
    parameter int HEART_BITS    = 23,
    parameter bit AUTO_RUN      = 1'b0,
    parameter bit WRAP          = 1'b1
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic                          i_button,
    input  logic [NUM_MSGS*ADDR_BITS-1:0] i_start_addrs,
    input  logic                          i_cont_busy,
    input  logic                          i_cont_error,
    output logic                          o_cont_stb,
    output logic [ADDR_BITS-1:0]          o_start_addr,
    output logic [IDX_BITS-1:0]           o_msg_index,
    output logic                          o_done,
    output logic                          o_fault,
    output logic                          o_logan_strobe,
    output logic [3:0]                    o_led
);

    typedef enum logic [2:0] {
        S_IDLE, S_STROBE, S_ARM, S_WAIT, S_NEXT, S_DONE, S_FAULT
    } state_t;

    localparam logic [IDX_BITS-1:0]      LAST_IDX = IDX_BITS'(NUM_MSGS - 1);
    localparam logic [DEBOUNCE_BITS-1:0] DB_LAST  = '1;
    // Timer counts the current cycle too, so firing one short of all-ones
    // makes the timeout land exactly 2^TIMEOUT_BITS-1 cycles after entry.
    localparam logic [TIMEOUT_BITS-1:0]  TMO_LAST = TIMEOUT_BITS'((1 << TIMEOUT_BITS) - 2);

    logic                     r_sync1, r_sync2;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic                     r_db, r_db_q;
    logic                     w_press;

    state_t                   r_state, w_state_nxt;
    logic [IDX_BITS-1:0]      r_idx, w_idx_nxt;
    logic [ADDR_BITS-1:0]     r_start_addr;
    logic [TIMEOUT_BITS-1:0]  r_tmo_cnt;
    logic                     w_tmo;
    logic                     w_enter_strobe, w_enter_wait, w_timing;
    logic                     r_logan;
    logic [HEART_BITS-1:0]    r_heart;
    logic [ADDR_BITS-1:0]     w_slot [2**IDX_BITS];

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
        end
    end

    // Only an unbroken run of disagreeing samples flips the level; any agreeing sample restarts it.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_db_cnt <= '0;
            r_db     <= 1'b0;
            r_db_q   <= 1'b0;
        end else begin
            r_db_q <= r_db;
            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt <= '0;
                r_db     <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_db & ~r_db_q;

    // Slots beyond NUM_MSGS read as zero; the index never reaches them.
    for (genvar g = 0; g < 2**IDX_BITS; g++) begin : g_slot
        if (g < NUM_MSGS) begin : g_used
            assign w_slot[g] = i_start_addrs[g*ADDR_BITS +: ADDR_BITS];
        end else begin : g_unused
            assign w_slot[g] = '0;
        end
    end

    assign w_tmo = (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE:   if (w_press) w_state_nxt = S_STROBE;
            S_STROBE: w_state_nxt = S_ARM;
            S_ARM: begin
                if (i_cont_busy)  w_state_nxt = S_WAIT;
                else if (w_tmo)   w_state_nxt = S_FAULT;
            end
            S_WAIT: begin
                if (!i_cont_busy) w_state_nxt = i_cont_error ? S_FAULT : S_NEXT;
                else if (w_tmo)   w_state_nxt = S_FAULT;
            end
            S_NEXT: begin
                if (r_idx == LAST_IDX) begin
                    if (WRAP) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = AUTO_RUN ? S_STROBE : S_IDLE;
                end
            end
            S_DONE:   w_state_nxt = S_DONE;
            S_FAULT:  w_state_nxt = S_FAULT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_strobe = (w_state_nxt == S_STROBE) && (r_state != S_STROBE);
    assign w_enter_wait   = (w_state_nxt == S_WAIT)   && (r_state != S_WAIT);
    assign w_timing       = (r_state == S_STROBE) || (r_state == S_ARM) || (r_state == S_WAIT);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_start_addr <= '0;
            r_logan      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            // Address follows the index the strobe will use, including the auto-run increment.
            if (w_enter_strobe)
                r_start_addr <= w_slot[w_idx_nxt];
            if (r_state == S_IDLE && w_press)
                r_logan <= 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I)
            r_tmo_cnt <= '0;
        else if (w_enter_strobe || w_enter_wait)
            r_tmo_cnt <= '0;
        else if (w_timing)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) r_heart <= '0;
        else        r_heart <= r_heart + 1'b1;
    end

    assign o_cont_stb     = (r_state == S_STROBE);
    assign o_start_addr   = r_start_addr;
    assign o_msg_index    = r_idx;
    assign o_done         = (r_state == S_DONE);
    assign o_fault        = (r_state == S_FAULT);
    assign o_logan_strobe = r_logan;
    assign o_led[0]       = ~(w_timing || (r_state == S_NEXT));
    assign o_led[1]       = ~o_done;
    assign o_led[2]       = ~o_fault;
    assign o_led[3]       = ~r_heart[HEART_BITS-1];

endmodule

// File: tb/tb_hd44780_msg_sequencer.sv
// Directed bench: one-per-press/wrap instance (A) and auto-run/no-wrap instance (B),
// each driven by a small controller model (busy 1 cycle after strobe, held 5 cycles).
module tb_hd44780_msg_sequencer;

    localparam int AB = 8;
    localparam int NM = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM*AB-1:0] slots = {8'h40, 8'h20, 8'h00};
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic       a_btn = 1'b0, a_noresp = 1'b0, a_errmode = 1'b0;
    logic       a_busy, a_stb, a_done, a_fault, a_logan;
    logic [7:0] a_addr;
    logic [1:0] a_idx;
    logic [3:0] a_led;

    logic       b_btn = 1'b0, b_err = 1'b0;
    logic       b_busy, b_stb, b_done, b_fault, b_logan;
    logic [7:0] b_addr;
    logic [1:0] b_idx;
    logic [3:0] b_led;

    hd44780_msg_sequencer #(
        .ADDR_BITS(AB), .NUM_MSGS(NM), .IDX_BITS(2), .DEBOUNCE_BITS(2),
        .TIMEOUT_BITS(4), .HEART_BITS(23), .AUTO_RUN(1'b0), .WRAP(1'b1)
    ) u_a (
        .CLK_I(clk), .RST_I(rst_n), .i_button(a_btn), .i_start_addrs(slots),
        .i_cont_busy(a_busy), .i_cont_error(a_errmode), .o_cont_stb(a_stb),
        .o_start_addr(a_addr), .o_msg_index(a_idx), .o_done(a_done), .o_fault(a_fault),
        .o_logan_strobe(a_logan), .o_led(a_led)
    );

    hd44780_msg_sequencer #(
        .ADDR_BITS(AB), .NUM_MSGS(NM), .IDX_BITS(2), .DEBOUNCE_BITS(2),
        .TIMEOUT_BITS(4), .HEART_BITS(23), .AUTO_RUN(1'b1), .WRAP(1'b0)
    ) u_b (
        .CLK_I(clk), .RST_I(rst_n), .i_button(b_btn), .i_start_addrs(slots),
        .i_cont_busy(b_busy), .i_cont_error(b_err), .o_cont_stb(b_stb),
        .o_start_addr(b_addr), .o_msg_index(b_idx), .o_done(b_done), .o_fault(b_fault),
        .o_logan_strobe(b_logan), .o_led(b_led)
    );

    // Controller models
    int a_bcnt, b_bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  a_bcnt <= 0;
        else if (a_stb && !a_noresp) a_bcnt <= 5;
        else if (a_bcnt > 0)         a_bcnt <= a_bcnt - 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          b_bcnt <= 0;
        else if (b_stb)      b_bcnt <= 5;
        else if (b_bcnt > 0) b_bcnt <= b_bcnt - 1;
    end
    assign a_busy = (a_bcnt != 0);
    assign b_busy = (b_bcnt != 0);

    // Strobe / fault-rise logs, sampled on the falling edge
    int         a_sc[$], b_sc[$], a_fr[$];
    logic [7:0] a_sa[$], b_sa[$];
    logic       a_fq = 1'b0;
    always @(negedge clk) begin
        if (a_stb) begin a_sc.push_back(cyc); a_sa.push_back(a_addr); end
        if (b_stb) begin b_sc.push_back(cyc); b_sa.push_back(b_addr); end
        if (a_fault && !a_fq) a_fr.push_back(cyc);
        a_fq = a_fault;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the button; returns 9 cycles later with the button still held.
    task automatic press(input bit sel, output int m);
        @(negedge clk);
        m = cyc;
        if (sel) b_btn = 1'b1;
        else     a_btn = 1'b1;
        tick(9);
    endtask

    task automatic release_btn();
        a_btn = 1'b0;
        b_btn = 1'b0;
        tick(15);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    int         m, base, fbase;
    int         ms[4];
    logic [7:0] wexp[4] = '{8'h00, 8'h20, 8'h40, 8'h00};

    initial begin
        tick(3);
        chk("rst_stb",   a_stb,   1'b0);
        chk("rst_addr",  a_addr,  8'h00);
        chk("rst_idx",   a_idx,   2'd0);
        chk("rst_done",  a_done,  1'b0);
        chk("rst_fault", a_fault, 1'b0);
        chk("rst_logan", a_logan, 1'b0);
        chk("rst_led_a", a_led,   4'hF);
        chk("rst_led_b", b_led,   4'hF);
        rst_n = 1'b1;
        tick(2);

        // Bounce: toggling every cycle never survives the debounce window
        for (int i = 0; i < 10; i++) begin a_btn = ~a_btn; tick(1); end
        a_btn = 1'b0;
        tick(20);
        chk("bounce_nostb", a_sc.size(), 0);
        chk("bounce_logan", a_logan, 1'b0);

        // Clean press
        press(1'b0, m);
        chk("p1_busy", a_busy, 1'b1);
        chk("p1_led_run", a_led, 4'b1110);
        release_btn();
        chk("p1_nstb", a_sc.size(), 1);
        chk("p1_stbcyc", a_sc.size() > 0 ? a_sc[0] : -1, m + 7);
        chk("p1_addr", a_sa.size() > 0 ? a_sa[0] : 8'hFF, 8'h00);
        chk("p1_idx", a_idx, 2'd1);
        chk("p1_logan", a_logan, 1'b1);
        chk("p1_led_idle", a_led, 4'hF);

        // Wrap: four presses
        do_reset();
        base = a_sc.size();
        for (int i = 0; i < 4; i++) begin press(1'b0, ms[i]); release_btn(); end
        chk("wrap_nstb", a_sc.size(), base + 4);
        for (int i = 0; i < 4; i++) begin
            if (a_sc.size() > base + i) begin
                chk($sformatf("wrap_addr%0d", i), a_sa[base+i], wexp[i]);
                chk($sformatf("wrap_cyc%0d", i), a_sc[base+i], ms[i] + 7);
            end
        end
        chk("wrap_idx", a_idx, 2'd1);

        // Controller never answers: timeout fault 15 cycles after strobe
        do_reset();
        a_noresp = 1'b1;
        base  = a_sc.size();
        fbase = a_fr.size();
        press(1'b0, m);
        release_btn();
        tick(5);
        chk("nb_nstb", a_sc.size(), base + 1);
        chk("nb_fault_cyc", a_fr.size() > fbase ? a_fr[fbase] : -1, m + 22);
        chk("nb_fault", a_fault, 1'b1);
        chk("nb_led", a_led, 4'b1011);
        press(1'b0, m);
        release_btn();
        chk("nb_ignore", a_sc.size(), base + 1);
        chk("nb_fault_held", a_fault, 1'b1);
        a_noresp = 1'b0;

        // Busy falls with error set
        do_reset();
        a_errmode = 1'b1;
        fbase = a_fr.size();
        press(1'b0, m);
        release_btn();
        chk("err_fault_cyc", a_fr.size() > fbase ? a_fr[fbase] : -1, m + 14);
        chk("err_fault", a_fault, 1'b1);
        a_errmode = 1'b0;

        // Reset asserted while waiting on the second message
        do_reset();
        press(1'b0, m);
        release_btn();
        press(1'b0, m);
        chk("mw_addr_pre", a_addr, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_stb",   a_stb,   1'b0);
        chk("mw_addr",  a_addr,  8'h00);
        chk("mw_idx",   a_idx,   2'd0);
        chk("mw_logan", a_logan, 1'b0);
        chk("mw_led",   a_led,   4'hF);
        a_btn = 1'b0;
        tick(3);
        rst_n = 1'b1;
        base = a_sc.size();
        tick(20);
        chk("mw_nostb", a_sc.size(), base);
        press(1'b0, m);
        release_btn();
        chk("mw_nstb", a_sc.size(), base + 1);
        chk("mw_new_addr", a_sc.size() > base ? a_sa[base] : 8'hFF, 8'h00);
        chk("mw_new_cyc", a_sc.size() > base ? a_sc[base] : -1, m + 7);

        // Auto-run, no wrap
        do_reset();
        base = b_sc.size();
        press(1'b1, m);
        release_btn();
        tick(15);
        chk("ar_nstb", b_sc.size(), base + 3);
        for (int i = 0; i < 3; i++) begin
            if (b_sc.size() > base + i) begin
                chk($sformatf("ar_addr%0d", i), b_sa[base+i], wexp[i]);
                chk($sformatf("ar_cyc%0d", i), b_sc[base+i], m + 7 + 8*i);
            end
        end
        chk("ar_done", b_done, 1'b1);
        chk("ar_led", b_led[2:0], 3'b101);
        chk("ar_logan", b_logan, 1'b1);
        press(1'b1, m);
        release_btn();
        chk("ar_ignore", b_sc.size(), base + 3);
        chk("ar_done_held", b_done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
